// File: rtl/race_pkg.sv
// Shared definitions for the drag-race timer: FSM state encoding and BCD digit constants.
package race_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_SAT  = 2'd3
    } race_state_t;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam logic [BCD_W-1:0] BCD_ONE = 4'd1;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous level into clk and emits a one-cycle tick on each rising edge.
// Shared with the game's button inputs.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;

    // Synchroniser chain plus one-cycle-delayed copy of its output for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev   <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick = sync_q[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/race_timer.sv
// Drag-race stopwatch: counts synchronised slow-clock ticks into a 4-digit BCD ss.cc time
// under a start/stop/clear FSM. Optional lap capture is enabled by defining RACE_TIMER_LAP_EN.
module race_timer
    import race_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned TICKS_PER_COUNT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slow_clk_in,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
`ifdef RACE_TIMER_LAP_EN
    input  logic             lap,
    output logic [15:0]      lap_time,
    output logic             lap_valid,
`endif
    output logic [BCD_W-1:0] cs_lo,
    output logic [BCD_W-1:0] cs_hi,
    output logic [BCD_W-1:0] s_lo,
    output logic [BCD_W-1:0] s_hi,
    output logic             running,
    output logic             saturated
);

    localparam int unsigned PS_W = (TICKS_PER_COUNT > 1) ? $clog2(TICKS_PER_COUNT) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_COUNT - 1);

    race_state_t       state, state_next;
    logic [PS_W-1:0]   ps_cnt, ps_next;
    logic [BCD_W-1:0]  cs_lo_next, cs_hi_next, s_lo_next, s_hi_next;
    logic              tick;
    logic              inc;
    logic              at_max;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (slow_clk_in),
        .tick     (tick)
    );

    assign at_max = (s_hi == BCD_MAX) && (s_lo == BCD_MAX) &&
                    (cs_hi == BCD_MAX) && (cs_lo == BCD_MAX);

    // State, prescaler, digit and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ps_cnt    <= '0;
            cs_lo     <= '0;
            cs_hi     <= '0;
            s_lo      <= '0;
            s_hi      <= '0;
            running   <= 1'b0;
            saturated <= 1'b0;
        end else begin
            state     <= state_next;
            ps_cnt    <= ps_next;
            cs_lo     <= cs_lo_next;
            cs_hi     <= cs_hi_next;
            s_lo      <= s_lo_next;
            s_hi      <= s_hi_next;
            running   <= (state_next == ST_RUN);
            saturated <= (state_next == ST_SAT);
        end
    end

    // Next state, prescaler and BCD increment with clear > stop > start priority
    always_comb begin
        state_next = state;
        ps_next    = ps_cnt;
        cs_lo_next = cs_lo;
        cs_hi_next = cs_hi;
        s_lo_next  = s_lo;
        s_hi_next  = s_hi;
        inc        = 1'b0;

        if (clear) begin
            state_next = ST_IDLE;
            ps_next    = '0;
            cs_lo_next = '0;
            cs_hi_next = '0;
            s_lo_next  = '0;
            s_hi_next  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_next = ST_RUN;
                        ps_next    = '0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_next = ST_STOP;
                    end else if (tick) begin
                        if (ps_cnt == PS_LAST) begin
                            ps_next = '0;
                            inc     = 1'b1;
                        end else begin
                            ps_next = ps_cnt + PS_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (start) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end

        // At 99.99 an increment saturates instead of wrapping
        if (inc) begin
            if (at_max) begin
                state_next = ST_SAT;
            end else if (cs_lo != BCD_MAX) begin
                cs_lo_next = cs_lo + BCD_ONE;
            end else begin
                cs_lo_next = '0;
                if (cs_hi != BCD_MAX) begin
                    cs_hi_next = cs_hi + BCD_ONE;
                end else begin
                    cs_hi_next = '0;
                    if (s_lo != BCD_MAX) begin
                        s_lo_next = s_lo + BCD_ONE;
                    end else begin
                        s_lo_next = '0;
                        s_hi_next = s_hi + BCD_ONE;
                    end
                end
            end
        end
    end

`ifdef RACE_TIMER_LAP_EN
    logic lap_prev;
    logic lap_rise;

    assign lap_rise = lap & ~lap_prev;

    // Lap capture: snapshot the running time on a rising lap edge while in RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_prev  <= 1'b0;
            lap_time  <= '0;
            lap_valid <= 1'b0;
        end else begin
            lap_prev  <= lap;
            lap_valid <= ~clear & lap_rise & (state == ST_RUN);
            if (clear) begin
                lap_time <= '0;
            end else if (lap_rise && (state == ST_RUN)) begin
                lap_time <= {s_hi, s_lo, cs_hi, cs_lo};
            end
        end
    end
`endif

endmodule
